// File: rtl/exec_mem_stage.sv
// MIPS execute stage: ALU, mul/div with HI/LO, decode forwarding and branch resolution,
// plus the EX/MEM pipeline register.
module exec_mem_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] id_pc,
   input  logic [31:0] id_rdata1,
   input  logic [31:0] id_rdata2,
   input  logic [31:0] id_imm,
   input  logic [4:0]  id_alu_op,
   input  logic        id_rt_sel,
   input  logic [2:0]  id_rf_wsel,
   input  logic [4:0]  id_rd,
   input  logic        id_rf_nwe,
   input  logic [1:0]  id_hilo_we,
   input  logic [31:0] if_pc,
   input  logic [31:0] imm,
   input  logic [3:0]  npc_op,
   input  logic [31:0] rdata1,
   input  logic [31:0] rdata2,
   input  logic [31:0] ram_out,
   input  logic [2:0]  rs_haz,
   input  logic [2:0]  rt_haz,
   output logic [31:0] alu_out,
   output logic        exe_stall,
   output logic [31:0] out_rdata1,
   output logic [31:0] out_rdata2,
   output logic        jmp,
   output logic [31:0] dest,
   output logic [31:0] ex_pc,
   output logic [31:0] ex_result,
   output logic [4:0]  ex_rd,
   output logic        ex_rf_nwe
);

   localparam logic [4:0] OpAdd   = 5'd0;
   localparam logic [4:0] OpSub   = 5'd1;
   localparam logic [4:0] OpAnd   = 5'd2;
   localparam logic [4:0] OpOr    = 5'd3;
   localparam logic [4:0] OpXor   = 5'd4;
   localparam logic [4:0] OpNor   = 5'd5;
   localparam logic [4:0] OpSlt   = 5'd6;
   localparam logic [4:0] OpSltu  = 5'd7;
   localparam logic [4:0] OpSllv  = 5'd8;
   localparam logic [4:0] OpSrlv  = 5'd9;
   localparam logic [4:0] OpSrav  = 5'd10;
   localparam logic [4:0] OpLui   = 5'd11;
   localparam logic [4:0] OpMult  = 5'd12;
   localparam logic [4:0] OpMultu = 5'd13;
   localparam logic [4:0] OpDiv   = 5'd14;
   localparam logic [4:0] OpDivu  = 5'd15;
   localparam logic [4:0] OpPassA = 5'd16;
   localparam logic [4:0] OpSll   = 5'd17;
   localparam logic [4:0] OpSrl   = 5'd18;
   localparam logic [4:0] OpSra   = 5'd19;

   logic [31:0] a, b;
   logic [31:0] hi_q, lo_q;
   logic [31:0] ex_val;

   assign a = id_rdata1;
   assign b = id_rt_sel ? id_imm : id_rdata2;

   always_comb begin
      alu_out = 32'd0;
      case (id_alu_op)
         OpAdd:   alu_out = a + b;
         OpSub:   alu_out = a - b;
         OpAnd:   alu_out = a & b;
         OpOr:    alu_out = a | b;
         OpXor:   alu_out = a ^ b;
         OpNor:   alu_out = ~(a | b);
         OpSlt:   alu_out = {31'd0, $signed(a) < $signed(b)};
         OpSltu:  alu_out = {31'd0, a < b};
         OpSllv:  alu_out = b << a[4:0];
         OpSrlv:  alu_out = b >> a[4:0];
         OpSrav:  alu_out = $unsigned($signed(b) >>> a[4:0]);
         OpLui:   alu_out = {b[15:0], 16'd0};
         OpPassA: alu_out = a;
         OpSll:   alu_out = b << id_imm[10:6];
         OpSrl:   alu_out = b >> id_imm[10:6];
         OpSra:   alu_out = $unsigned($signed(b) >>> id_imm[10:6]);
         default: alu_out = 32'd0;
      endcase
   end

   // Signed product is the low 64 bits of the product of sign-extended operands.
   logic        is_mult_s;
   logic [63:0] mul_a, mul_b, product;

   assign is_mult_s = (id_alu_op == OpMult);
   assign mul_a     = {{32{is_mult_s & a[31]}}, a};
   assign mul_b     = {{32{is_mult_s & b[31]}}, b};
   assign product   = mul_a * mul_b;

   logic        is_div, div_signed, div_done;
   logic        a_neg, b_neg;
   logic [31:0] a_mag, b_mag;
   logic [5:0]  div_cnt_q;
   logic [31:0] div_quo_q, div_rem_q;
   logic [31:0] q_in, r_in, q_next, r_next;
   logic [32:0] trial;
   logic [31:0] quotient, remainder;

   assign is_div     = (id_alu_op == OpDiv) || (id_alu_op == OpDivu);
   assign div_signed = (id_alu_op == OpDiv);
   assign div_done   = (div_cnt_q == 6'd32);
   assign exe_stall  = is_div & ~div_done & ~rst;

   assign a_neg = div_signed & a[31];
   assign b_neg = div_signed & b[31];
   assign a_mag = a_neg ? (~a + 32'd1) : a;
   assign b_mag = b_neg ? (~b + 32'd1) : b;

   // First step takes the dividend straight from the operand so 32 steps fit in 32 stall cycles.
   always_comb begin
      q_in  = (div_cnt_q == 6'd0) ? a_mag : div_quo_q;
      r_in  = (div_cnt_q == 6'd0) ? 32'd0 : div_rem_q;
      trial = {r_in, q_in[31]};
      if (trial >= {1'b0, b_mag}) begin
         r_next = trial[31:0] - b_mag;
         q_next = {q_in[30:0], 1'b1};
      end else begin
         r_next = trial[31:0];
         q_next = {q_in[30:0], 1'b0};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt_q <= 6'd0;
         div_quo_q <= 32'd0;
         div_rem_q <= 32'd0;
      end else if (is_div && !div_done) begin
         div_cnt_q <= div_cnt_q + 6'd1;
         div_quo_q <= q_next;
         div_rem_q <= r_next;
      end else begin
         div_cnt_q <= 6'd0;
      end
   end

   always_comb begin
      if (b == 32'd0) begin
         quotient  = 32'hFFFF_FFFF;
         remainder = a;
      end else begin
         quotient  = (a_neg ^ b_neg) ? (~div_quo_q + 32'd1) : div_quo_q;
         remainder = a_neg ? (~div_rem_q + 32'd1) : div_rem_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hi_q <= 32'd0;
         lo_q <= 32'd0;
      end else if (!exe_stall && (id_hilo_we != 2'b00)) begin
         if (id_alu_op == OpMult || id_alu_op == OpMultu) begin
            hi_q <= product[63:32];
            lo_q <= product[31:0];
         end else if (is_div) begin
            hi_q <= remainder;
            lo_q <= quotient;
         end else begin
            if (id_hilo_we[1]) hi_q <= a;
            if (id_hilo_we[0]) lo_q <= a;
         end
      end
   end

   always_comb begin
      case (id_rf_wsel)
         3'd1:    ex_val = id_pc + 32'd8;
         3'd2:    ex_val = hi_q;
         3'd3:    ex_val = lo_q;
         default: ex_val = alu_out;
      endcase
   end

   assign out_rdata1 = rs_haz[2] ? ex_val : rs_haz[1] ? ram_out : rs_haz[0] ? ex_result : rdata1;
   assign out_rdata2 = rt_haz[2] ? ex_val : rt_haz[1] ? ram_out : rt_haz[0] ? ex_result : rdata2;

   logic [31:0] pc4;
   logic        rs_zero, rs_neg;

   assign pc4     = if_pc + 32'd4;
   assign rs_zero = (out_rdata1 == 32'd0);
   assign rs_neg  = out_rdata1[31];

   always_comb begin
      jmp  = 1'b0;
      dest = pc4 + {imm[29:0], 2'b00};
      case (npc_op)
         4'd1:    jmp = (out_rdata1 == out_rdata2);
         4'd2:    jmp = (out_rdata1 != out_rdata2);
         4'd3:    jmp = ~rs_neg;
         4'd4:    jmp = ~rs_neg & ~rs_zero;
         4'd5:    jmp = rs_neg | rs_zero;
         4'd6:    jmp = rs_neg;
         4'd7: begin
            jmp  = 1'b1;
            dest = {pc4[31:28], imm[25:0], 2'b00};
         end
         4'd8: begin
            jmp  = 1'b1;
            dest = out_rdata1;
         end
         default: jmp = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_pc     <= 32'd0;
         ex_result <= 32'd0;
         ex_rd     <= 5'd0;
         ex_rf_nwe <= 1'b0;
      end else if (exe_stall) begin
         ex_pc     <= 32'd0;
         ex_result <= 32'd0;
         ex_rd     <= 5'd0;
         ex_rf_nwe <= 1'b0;
      end else begin
         ex_pc     <= id_pc;
         ex_result <= ex_val;
         ex_rd     <= id_rd;
         ex_rf_nwe <= id_rf_nwe;
      end
   end

endmodule

// File: tb/tb_exec_mem_stage.sv
// Scoreboard bench for exec_mem_stage: stimulus queues cycle-tagged expectations,
// a negedge monitor compares them against the DUT.
module tb_exec_mem_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] id_pc, id_rdata1, id_rdata2, id_imm;
   logic [4:0]  id_alu_op;
   logic        id_rt_sel;
   logic [2:0]  id_rf_wsel;
   logic [4:0]  id_rd;
   logic        id_rf_nwe;
   logic [1:0]  id_hilo_we;
   logic [31:0] if_pc, imm;
   logic [3:0]  npc_op;
   logic [31:0] rdata1, rdata2, ram_out;
   logic [2:0]  rs_haz, rt_haz;
   logic [31:0] alu_out, out_rdata1, out_rdata2, dest, ex_pc, ex_result;
   logic        exe_stall, jmp, ex_rf_nwe;
   logic [4:0]  ex_rd;

   exec_mem_stage dut (
      .clk(clk), .rst(rst), .id_pc(id_pc), .id_rdata1(id_rdata1), .id_rdata2(id_rdata2),
      .id_imm(id_imm), .id_alu_op(id_alu_op), .id_rt_sel(id_rt_sel), .id_rf_wsel(id_rf_wsel),
      .id_rd(id_rd), .id_rf_nwe(id_rf_nwe), .id_hilo_we(id_hilo_we), .if_pc(if_pc),
      .imm(imm), .npc_op(npc_op), .rdata1(rdata1), .rdata2(rdata2), .ram_out(ram_out),
      .rs_haz(rs_haz), .rt_haz(rt_haz), .alu_out(alu_out), .exe_stall(exe_stall),
      .out_rdata1(out_rdata1), .out_rdata2(out_rdata2), .jmp(jmp), .dest(dest),
      .ex_pc(ex_pc), .ex_result(ex_result), .ex_rd(ex_rd), .ex_rf_nwe(ex_rf_nwe)
   );

   always #5 clk = ~clk;

   localparam int SAluOut = 0, SStall = 1, SRd1 = 2, SRd2 = 3, SJmp = 4, SDest = 5;
   localparam int SExPc = 6, SExRes = 7, SExRd = 8, SExNwe = 9;

   typedef struct {
      int          cyc;
      int          sel;
      logic [31:0] exp;
      string       name;
   } rec_t;

   rec_t sb[$];
   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;
   bit   done = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] get_sig(int sel);
      case (sel)
         SAluOut: return alu_out;
         SStall:  return {31'd0, exe_stall};
         SRd1:    return out_rdata1;
         SRd2:    return out_rdata2;
         SJmp:    return {31'd0, jmp};
         SDest:   return dest;
         SExPc:   return ex_pc;
         SExRes:  return ex_result;
         SExRd:   return {27'd0, ex_rd};
         default: return {31'd0, ex_rf_nwe};
      endcase
   endfunction

   // d = 0: combinational, seen this cycle; d = 1: registered, seen after the next edge.
   task automatic expect_sig(input string name, input int sel, input logic [31:0] v,
                             input int d);
      rec_t r;
      r.cyc  = cyc + d;
      r.sel  = sel;
      r.exp  = v;
      r.name = name;
      sb.push_back(r);
   endtask

   always @(negedge clk) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].cyc == cyc) begin
            logic [31:0] act;
            act = get_sig(sb[i].sel);
            checks++;
            if (act !== sb[i].exp) begin
               errors++;
               $display("FAIL %s: got %h expected %h (cycle %0d)", sb[i].name, act,
                        sb[i].exp, cyc);
            end
            sb.delete(i);
         end else if (sb[i].cyc < cyc) begin
            checks++;
            errors++;
            $display("FAIL %s: never sampled, expected %h", sb[i].name, sb[i].exp);
            sb.delete(i);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic ex_op(input logic [31:0] pc, input logic [31:0] av, input logic [31:0] bv,
                        input logic [4:0] op, input logic [2:0] wsel, input logic [4:0] rd,
                        input logic nwe, input logic [1:0] hw);
      id_pc = pc; id_rdata1 = av; id_rdata2 = bv; id_imm = 32'd0; id_rt_sel = 1'b0;
      id_alu_op = op; id_rf_wsel = wsel; id_rd = rd; id_rf_nwe = nwe; id_hilo_we = hw;
   endtask

   initial begin
      ex_op(32'd0, 32'd0, 32'd0, 5'd0, 3'd0, 5'd0, 1'b0, 2'b00);
      if_pc = 0; imm = 0; npc_op = 0; rdata1 = 0; rdata2 = 0; ram_out = 0;
      rs_haz = 0; rt_haz = 0;
      repeat (3) step();
      rst = 1'b0;
      expect_sig("reset stall", SStall, 0, 0);
      expect_sig("reset ex_pc", SExPc, 0, 0);
      expect_sig("reset ex_rd", SExRd, 0, 0);
      expect_sig("reset ex_result", SExRes, 0, 0);
      step();

      // ADD and forwarding priority
      ex_op(32'h1000, 32'd5, 32'd7, 5'd0, 3'd0, 5'd3, 1'b1, 2'b00);
      ram_out = 32'hAA; rdata1 = 32'h55; rs_haz = 3'b100;
      expect_sig("add alu_out", SAluOut, 32'd12, 0);
      expect_sig("fwd ex", SRd1, 32'd12, 0);
      expect_sig("add ex_result", SExRes, 32'd12, 1);
      expect_sig("add ex_rd", SExRd, 32'd3, 1);
      expect_sig("add ex_nwe", SExNwe, 32'd1, 1);
      expect_sig("add ex_pc", SExPc, 32'h1000, 1);
      step();
      rs_haz = 3'b010; expect_sig("fwd mem load", SRd1, 32'hAA, 0); step();
      rs_haz = 3'b110; expect_sig("fwd ex priority", SRd1, 32'd12, 0); step();
      rs_haz = 3'b000; expect_sig("fwd none", SRd1, 32'h55, 0); step();
      rs_haz = 3'b001; ex_op(32'h1004, 32'd1, 32'd1, 5'd0, 3'd0, 5'd0, 1'b0, 2'b00);
      expect_sig("fwd mem reg", SRd1, 32'd12, 0);
      rt_haz = 3'b100; expect_sig("fwd rt ex", SRd2, 32'd2, 0);
      step();
      rs_haz = 3'b000; rt_haz = 3'b000;

      // Assorted ALU ops
      ex_op(0, 32'd3, 32'd5, 5'd1, 3'd0, 5'd0, 1'b0, 2'b00);
      expect_sig("sub", SAluOut, 32'hFFFF_FFFE, 0); step();
      ex_op(0, 32'hFFFF_FFFF, 32'd1, 5'd6, 3'd0, 5'd0, 1'b0, 2'b00);
      expect_sig("slt", SAluOut, 32'd1, 0); step();
      ex_op(0, 32'hFFFF_FFFF, 32'd1, 5'd7, 3'd0, 5'd0, 1'b0, 2'b00);
      expect_sig("sltu", SAluOut, 32'd0, 0); step();
      ex_op(0, 32'd4, 32'h8000_0000, 5'd10, 3'd0, 5'd0, 1'b0, 2'b00);
      expect_sig("srav", SAluOut, 32'hF800_0000, 0); step();
      ex_op(0, 32'd0, 32'd0, 5'd17, 3'd0, 5'd0, 1'b0, 2'b00);
      id_rt_sel = 1'b1; id_imm = 32'h0000_0083;
      expect_sig("sll imm", SAluOut, 32'h0000_0083 << 2, 0); step();
      ex_op(0, 32'd0, 32'h1234, 5'd11, 3'd0, 5'd0, 1'b0, 2'b00);
      expect_sig("lui", SAluOut, 32'h1234_0000, 0); step();
      ex_op(0, 32'hF0F0_0000, 32'h0F0F_0000, 5'd5, 3'd0, 5'd0, 1'b0, 2'b00);
      expect_sig("nor", SAluOut, 32'h0000_FFFF, 0); step();
      ex_op(32'h300, 32'd0, 32'd0, 5'd0, 3'd1, 5'd31, 1'b1, 2'b00);
      expect_sig("link pc+8", SExRes, 32'h308, 1); step();

      // MULT and HI/LO readback
      ex_op(0, 32'hFFFF_FFFE, 32'd3, 5'd12, 3'd0, 5'd0, 1'b0, 2'b11);
      expect_sig("mult alu_out", SAluOut, 32'd0, 0); step();
      ex_op(0, 32'd0, 32'd0, 5'd16, 3'd3, 5'd0, 1'b0, 2'b00); rs_haz = 3'b100;
      expect_sig("mult lo", SRd1, 32'hFFFF_FFFA, 0);
      expect_sig("mult lo ex_result", SExRes, 32'hFFFF_FFFA, 1); step();
      id_rf_wsel = 3'd2; expect_sig("mult hi", SRd1, 32'hFFFF_FFFF, 0); step();
      ex_op(0, 32'hCAFE, 32'd0, 5'd16, 3'd0, 5'd0, 1'b0, 2'b10); step();
      id_hilo_we = 2'b00; id_rf_wsel = 3'd2;
      expect_sig("mthi hi", SRd1, 32'hCAFE, 0); step();
      id_rf_wsel = 3'd3; expect_sig("mthi lo kept", SRd1, 32'hFFFF_FFFA, 0); step();
      rs_haz = 3'b000;

      // DIV -7/2 with bubbles during the stall
      ex_op(32'h2000, 32'hFFFF_FFF9, 32'd2, 5'd14, 3'd0, 5'd5, 1'b1, 2'b11);
      for (int k = 0; k < 32; k++) begin
         expect_sig("div stall", SStall, 32'd1, 0);
         expect_sig("div bubble pc", SExPc, 32'd0, 1);
         expect_sig("div bubble nwe", SExNwe, 32'd0, 1);
         step();
      end
      expect_sig("div done stall", SStall, 32'd0, 0);
      expect_sig("div ex_pc", SExPc, 32'h2000, 1);
      expect_sig("div ex_rd", SExRd, 32'd5, 1);
      step();
      ex_op(0, 32'd0, 32'd0, 5'd16, 3'd3, 5'd0, 1'b0, 2'b00); rs_haz = 3'b100;
      expect_sig("div lo", SRd1, 32'hFFFF_FFFD, 0); step();
      id_rf_wsel = 3'd2; expect_sig("div hi", SRd1, 32'hFFFF_FFFF, 0); step();

      // DIVU by zero
      ex_op(32'h2100, 32'h1234, 32'd0, 5'd15, 3'd0, 5'd0, 1'b0, 2'b11); rs_haz = 3'b000;
      for (int k = 0; k < 32; k++) begin
         if (k == 0 || k == 31) expect_sig("divu stall", SStall, 32'd1, 0);
         step();
      end
      expect_sig("divu done stall", SStall, 32'd0, 0); step();
      ex_op(0, 32'd0, 32'd0, 5'd16, 3'd3, 5'd0, 1'b0, 2'b00); rs_haz = 3'b100;
      expect_sig("divu0 lo", SRd1, 32'hFFFF_FFFF, 0); step();
      id_rf_wsel = 3'd2; expect_sig("divu0 hi", SRd1, 32'h1234, 0); step();
      rs_haz = 3'b000;

      // Branch resolution
      ex_op(0, 32'd0, 32'd0, 5'd0, 3'd0, 5'd0, 1'b0, 2'b00);
      if_pc = 32'h100; imm = 32'd4; rdata1 = 32'd7; rdata2 = 32'd7; npc_op = 4'd1;
      expect_sig("beq jmp", SJmp, 32'd1, 0); expect_sig("beq dest", SDest, 32'h114, 0); step();
      npc_op = 4'd2; expect_sig("bne jmp", SJmp, 32'd0, 0); step();
      npc_op = 4'd6; rdata1 = 32'd0; expect_sig("bltz zero", SJmp, 32'd0, 0); step();
      npc_op = 4'd4; rdata1 = 32'hFFFF_FFFF; expect_sig("bgtz neg", SJmp, 32'd0, 0); step();
      npc_op = 4'd5; expect_sig("blez neg", SJmp, 32'd1, 0); step();
      npc_op = 4'd8; rs_haz = 3'b010; ram_out = 32'h400;
      expect_sig("jr jmp", SJmp, 32'd1, 0); expect_sig("jr dest", SDest, 32'h400, 0); step();
      npc_op = 4'd7; rs_haz = 3'b000; if_pc = 32'h1000_0100; imm = 32'h40;
      expect_sig("j dest", SDest, 32'h1000_0100, 0); step();
      npc_op = 4'd12; expect_sig("undef npc", SJmp, 32'd0, 0); step();
      npc_op = 4'd0;

      // Reset in the middle of a divide
      ex_op(32'h2200, 32'd100, 32'd3, 5'd14, 3'd0, 5'd7, 1'b1, 2'b11);
      repeat (5) step();
      rst = 1'b1;
      expect_sig("rst stall", SStall, 32'd0, 0);
      expect_sig("rst ex_pc", SExPc, 32'd0, 0);
      expect_sig("rst ex_result", SExRes, 32'd0, 0);
      expect_sig("rst ex_rd", SExRd, 32'd0, 0);
      expect_sig("rst ex_nwe", SExNwe, 32'd0, 0);
      step();
      ex_op(0, 32'd0, 32'd0, 5'd16, 3'd3, 5'd0, 1'b0, 2'b00); rs_haz = 3'b100;
      rst = 1'b0;
      expect_sig("rst lo", SRd1, 32'd0, 0); step();
      id_rf_wsel = 3'd2; expect_sig("rst hi", SRd1, 32'd0, 0); step();

      repeat (3) step();
      done = 1'b1;
   end

   initial begin
      fork
         wait (done);
         begin
            #100000;
            $display("FAIL watchdog: stimulus did not complete, expected completion");
            errors++;
         end
      join_any
      disable fork;
      @(negedge clk);
      #1;
      if (sb.size() != 0) begin
         errors += sb.size();
         $display("FAIL leftover: %0d unchecked entries, expected 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
